// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction/data memory arbiter.
// Holds FSM encodings, the default starvation limit and the RISC-V width codes.
// Also provides the latched-request record and a width-decode helper.
package mem_arbiter_pkg;

    // Arbiter FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Consecutive data grants tolerated while a fetch is waiting
    localparam int STARVE_MAX_DEF = 4;

    // RISC-V load/store func3 width codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size as decoded from the low func3 bits
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Everything about the winning request that must survive until RESP
    // (the address is kept separately because its width is a parameter)
    typedef struct packed {
        logic        grant_dm;
        logic        misalign;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_lat_t;

    // Signed and unsigned loads share the low two func3 bits, so the size
    // decode only needs those; anything that is not byte/half is a word.
    function automatic acc_size_t f3_size(input logic [1:0] f3_lo);
        acc_size_t sz;
        if (f3_lo == F3_SB[1:0]) begin
            sz = SZ_BYTE;
        end else if (f3_lo == F3_SH[1:0]) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: byte enables, store shift, load shift, misalign.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the arbiter decides when the results are used.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  func_3,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [4:0] shamt;

    // Sign/zero extension of narrow loads is done by the writeback stage,
    // so the unsigned bit of func3 is deliberately not looked at here.
    logic unused_f3_sign;
    assign unused_f3_sign = func_3[2];

    assign shamt = {off, 3'b000};

    // Byte enables and misalignment from access size and byte offset
    always_comb begin
        be         = 4'b1111;
        misaligned = 1'b0;
        case (f3_size(func_3[1:0]))
            SZ_BYTE: begin
                be = 4'b0001 << off;
            end
            SZ_HALF: begin
                be         = 4'b0011 << off;
                misaligned = off[0];
            end
            default: begin
                be         = 4'b1111;
                misaligned = (off != 2'b00);
            end
        endcase
        // Loads always read the full word; lane selection happens on return
        if (!we) begin
            be = 4'b1111;
        end
    end

    // Store data moves up to its lane, load data moves down to bit 0
    assign mem_wdata = wdata << shamt;
    assign rdata     = mem_rdata >> shamt;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory with starvation guard.
// Latency: request seen in IDLE at N, ack at N+2 earliest, ready pulse at N+3.
// Backpressure: requesters hold req until their ready pulse; o_stall reflects pending work.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch port
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ready,
    output logic [31:0]       o_if_rdata,
    // data port
    input  logic              i_dm_req,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [31:0]       i_dm_wdata,
    input  logic              i_dm_we,
    input  logic [2:0]        i_dm_func_3,
    output logic              o_dm_ready,
    output logic [31:0]       o_dm_rdata,
    output logic              o_dm_err,
    // memory port
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_be,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata,
    // pipeline stall
    output logic              o_stall
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              any_req;
    logic              fetch_forced;
    logic              grant_dm;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] lat_addr;
    req_lat_t          lat;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;

    logic [1:0]        al_off;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;
    logic              al_misalign;

    assign any_req      = i_if_req | i_dm_req;
    // Data normally wins; once the fetch has been passed over STARVE_MAX
    // times in a row it takes the next slot.
    assign fetch_forced = i_if_req & (starve_cnt == STARVE_LIM);
    assign grant_dm     = i_dm_req & ~fetch_forced;

    // In IDLE the aligner looks at the live data request so the misalign
    // short-cut can be taken immediately; afterwards it uses the latched
    // offset so the returning load word is shifted by the right amount.
    assign al_off = (state == ST_IDLE) ? i_dm_addr[1:0] : lat_addr[1:0];

    mem_lane_align u_align (
        .off        (al_off),
        .func_3     (i_dm_func_3),
        .we         (i_dm_we),
        .wdata      (i_dm_wdata),
        .mem_rdata  (i_mem_rdata),
        .be         (al_be),
        .mem_wdata  (al_wdata),
        .rdata      (al_rdata),
        .misaligned (al_misalign)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: misaligned data skips the memory entirely
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (grant_dm && al_misalign) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_mem_ack) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: memory request held ISSUE..WAIT, ready pulses in RESP
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = 4'b0000;
        o_if_ready  = 1'b0;
        o_dm_ready  = 1'b0;
        o_dm_err    = 1'b0;
        case (state)
            ST_ISSUE, ST_WAIT: begin
                o_mem_req   = 1'b1;
                o_mem_we    = lat.we;
                o_mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
                o_mem_wdata = lat.wdata;
                o_mem_be    = lat.be;
            end
            ST_RESP: begin
                o_if_ready = ~lat.grant_dm;
                o_dm_ready = lat.grant_dm;
                o_dm_err   = lat.grant_dm & lat.misalign;
            end
            default: begin
            end
        endcase
    end

    // Capture the winner and its memory command; inputs are only looked at in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr <= '0;
            lat      <= '0;
        end else if (state == ST_IDLE && any_req) begin
            lat.grant_dm <= grant_dm;
            if (grant_dm) begin
                lat_addr     <= i_dm_addr;
                lat.misalign <= al_misalign;
                lat.we       <= i_dm_we;
                lat.be       <= al_be;
                lat.wdata    <= al_wdata;
            end else begin
                lat_addr     <= i_if_addr;
                lat.misalign <= 1'b0;
                lat.we       <= 1'b0;
                lat.be       <= 4'b1111;
                lat.wdata    <= '0;
            end
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!i_if_req) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (!grant_dm) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Read data registers: loaded on the edge into RESP, held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (state == ST_WAIT && i_mem_ack) begin
            if (lat.grant_dm) begin
                dm_rdata_q <= al_rdata;
            end else begin
                if_rdata_q <= i_mem_rdata;
            end
        end else if (state == ST_IDLE && grant_dm && al_misalign) begin
            dm_rdata_q <= '0;
        end
    end

    assign o_if_rdata = if_rdata_q;
    assign o_dm_rdata = dm_rdata_q;

    // Each requester stalls until its own ready pulse
    assign o_stall = (i_if_req & ~o_if_ready) | (i_dm_req & ~o_dm_ready);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch waits.
REQ-002 Parameter ADDR_W, default 32: address width on every port.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 i_if_req  in  1  instruction fetch request; held high until o_if_ready.
REQ-007 i_if_addr  in  32  fetch address, word aligned.
REQ-008 o_if_ready  out  1  one-cycle pulse; fetch done, o_if_rdata valid.
REQ-009 o_if_rdata  out  32  fetched instruction word.
REQ-010 i_dm_req  in  1  data request from the memory stage; held until o_dm_ready.
REQ-011 i_dm_addr  in  32  data byte address (memory-stage ALU result).
REQ-012 i_dm_wdata  in  32  store value, right-aligned (byte/half in low bits).
REQ-013 i_dm_we  in  1  1 = store, 0 = load.
REQ-014 i_dm_func_3  in  3  RISC-V width code: LB/LH/LW/LBU/LHU, SB/SH/SW.
REQ-015 o_dm_ready  out  1  one-cycle pulse; data access done.
REQ-016 o_dm_rdata  out  32  load word right-shifted by addr[1:0]*8 (low bits valid).
REQ-017 o_dm_err  out  1  pulses with o_dm_ready on a misaligned access.
REQ-018 o_mem_req, o_mem_we  out  1 each  single-port memory request and write enable.
REQ-019 o_mem_addr  out  32  word address (byte address with [1:0]=0).
REQ-020 o_mem_wdata  out  32  lane-aligned write data.
REQ-021 o_mem_be  out  4  byte enables.
REQ-022 i_mem_ack  in  1  one-cycle completion pulse from memory, any latency >=1.
REQ-023 i_mem_rdata  in  32  read word, valid when i_mem_ack=1.
REQ-024 o_stall  out  1  high while any pending request is not yet completed.

Function
REQ-025 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE on any request; ISSUE->WAIT same cycle o_mem_req asserts; WAIT->RESP on i_mem_ack; RESP->IDLE after one cycle.
REQ-026 The winner SHALL be latched in IDLE; request inputs SHALL be sampled only then; later input changes are ignored until RESP.
REQ-027 Arbitration: data beats fetch on simultaneous requests, except when starve counter equals STARVE_MAX, then fetch wins.
REQ-028 Starve counter: +1 per data grant while i_if_req high; cleared on fetch grant or when i_if_req low; saturates at STARVE_MAX.
REQ-029 o_mem_req/addr/wdata/we/be SHALL be held stable from ISSUE until the i_mem_ack cycle inclusive, then zeroed.
REQ-030 Store lanes: SB be=0001<<a[1:0], SH be=0011<<a[1:0], SW be=1111; wdata shifted left by a[1:0]*8.
REQ-031 Loads and fetches SHALL drive be=1111, we=0.
REQ-032 Misaligned (halfword a[0]=1, word a[1:0]!=0): no memory access; IDLE->RESP directly; o_dm_ready and o_dm_err pulse; rdata=0.
REQ-033 o_if_ready/o_dm_ready pulse only in RESP, only for the granted requester; rdata held until next RESP.
REQ-034 Minimum latency: request in IDLE at cycle N, ack at N+2 -> ready at N+3.
REQ-035 o_stall = (i_if_req | i_dm_req) & ~(ready pulse for that requester) — combinational.
REQ-036 i_mem_ack outside WAIT SHALL be ignored.

Reset
REQ-037 On reset: state IDLE, starve counter 0, all outputs 0, latched rdata 0.
REQ-038 Reset mid-transaction SHALL abandon it without a ready pulse; a late i_mem_ack is ignored.

Structure
REQ-039 FSM state encodings and STARVE_MAX default SHALL live in the shared constants header; func_3 codes reuse existing LB..SW constants.
REQ-040 Lane alignment (be, wdata shift, rdata shift, misalign detect) SHALL be one combinational sub-module mem_lane_align.

Verification
REQ-041 Fetch only, addr 0x100, ack after 3 cycles, rdata 0x00500093 -> o_if_ready 1 cycle later, o_if_rdata 0x00500093.
REQ-042 SB addr 0x203 wdata 0xAB -> o_mem_addr 0x200, be 1000, wdata 0xAB000000, we 1.
REQ-043 LH addr 0x202, mem word 0xBEEF1234 -> o_dm_rdata low half 0xBEEF.
REQ-044 Both requesting continuously, STARVE_MAX=4 -> grant order D,D,D,D,F repeating.
REQ-045 LW addr 0x101 -> o_mem_req never high, o_dm_ready and o_dm_err pulse 1 cycle after request.
REQ-046 Reset asserted in WAIT, ack arrives next cycle -> no ready pulse, all outputs 0, next request serviced normally.
